// File: rtl/core_led_pio_ext.sv
// Avalon-MM LED/GPIO output port: DATA register with atomic SET/CLR/TOGGLE aliases,
// per-bit blink driven by a prescaled tick, and a global PWM brightness gate.
module core_led_pio_ext #(
  parameter int WIDTH    = 18,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50000,
  parameter int BLINK_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_TOGGLE = 3'd3;
  localparam logic [2:0] A_MODE   = 3'd4;
  localparam logic [2:0] A_PERIOD = 3'd5;
  localparam logic [2:0] A_DUTY   = 3'd6;

  // Bus: a write is accepted on every edge where chipselect=1 and write_n=0 (no
  // wait states); reads are combinational on address and show pre-edge state.
  logic                w_wr;
  logic [WIDTH-1:0]    w_wd;
  logic                w_unused_wd;
  logic                w_tick;
  logic                w_pwm_on;
  logic [WIDTH-1:0]    w_out_next;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mode;
  logic [BLINK_W-1:0]  r_period;
  logic [PWM_BITS-1:0] r_duty;
  logic [PS_W-1:0]     r_prescale;
  logic [BLINK_W-1:0]  r_tick_cnt;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_mode   <= '0;
      r_period <= BLINK_W'(500);
      r_duty   <= '1;
    end else if (w_wr) begin
      case (address)
        A_DATA:   r_data   <= w_wd;
        A_SET:    r_data   <= r_data | w_wd;
        A_CLR:    r_data   <= r_data & ~w_wd;
        A_TOGGLE: r_data   <= r_data ^ w_wd;
        A_MODE:   r_mode   <= w_wd;
        A_PERIOD: r_period <= writedata[BLINK_W-1:0];
        A_DUTY:   r_duty   <= writedata[PWM_BITS-1:0];
        default:  ;
      endcase
    end
  end

  assign w_tick = (r_prescale == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + PS_W'(1);
    end
  end

  // A PERIOD write restarts the blink cycle in the on phase, even on a tick edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_phase    <= 1'b1;
    end else if (w_wr && (address == A_PERIOD)) begin
      r_tick_cnt <= '0;
      r_phase    <= 1'b1;
    end else if (r_period == '0) begin
      r_tick_cnt <= '0;
      r_phase    <= 1'b1;
    end else if (w_tick) begin
      if (r_tick_cnt == (r_period - BLINK_W'(1))) begin
        r_tick_cnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_tick_cnt <= r_tick_cnt + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Full-scale duty is treated as always on rather than (2^N-1)/2^N.
  assign w_pwm_on   = (&r_duty) | (r_pwm_cnt < r_duty);
  assign w_out_next = r_data & (~r_mode | {WIDTH{r_phase}}) & {WIDTH{w_pwm_on}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= '0;
    end else begin
      out_port <= w_out_next;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      A_DATA:   readdata = 32'(r_data);
      A_MODE:   readdata = 32'(r_mode);
      A_PERIOD: readdata = 32'(r_period);
      A_DUTY:   readdata = 32'(r_duty);
      default:  readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_core_led_pio_ext.sv
// Bench for core_led_pio_ext: two instances (8-bit and 4-bit PWM) share one bus and are
// tracked against a cycle-count based model of registers, blink phase and PWM gating.
module tb_core_led_pio_ext;

  localparam int WIDTH = 18;
  localparam int PS    = 4;
  localparam logic [31:0] DMASK = 32'h0003FFFF;

  logic              clk;
  logic              rst;
  logic [2:0]        addr;
  logic              cs;
  logic              wn;
  logic [31:0]       wd;
  logic [31:0]       rd_a;
  logic [31:0]       rd_b;
  logic [WIDTH-1:0]  out_a;
  logic [WIDTH-1:0]  out_b;

  core_led_pio_ext #(.WIDTH(WIDTH), .PWM_BITS(8), .PRESCALE(PS), .BLINK_W(16)) dut_a (
    .clk(clk), .reset(rst), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .readdata(rd_a), .out_port(out_a)
  );

  core_led_pio_ext #(.WIDTH(WIDTH), .PWM_BITS(4), .PRESCALE(PS), .BLINK_W(16)) dut_b (
    .clk(clk), .reset(rst), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .readdata(rd_b), .out_port(out_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: n = edges since reset, ticks = prescaler ticks since the blink restarted
  logic [31:0] m_data, m_mode, m_period;
  logic [31:0] m_duty [2];
  logic [31:0] m_out  [2];
  int unsigned m_n, m_ticks;

  typedef struct {
    logic [2:0]  a;
    logic        c;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs [12];

  int cnt, last, nint, bad, prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_data = 0; m_mode = 0; m_period = 500;
    m_duty[0] = 255; m_duty[1] = 15;
    m_out[0] = 0; m_out[1] = 0;
    m_n = 0; m_ticks = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a, input int i);
    case (a)
      3'd0: return m_data;
      3'd4: return m_mode;
      3'd5: return m_period;
      3'd6: return m_duty[i];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step();
    bit wr, tick, phase, on;
    int md;
    logic [31:0] pm, dm;
    wr    = cs && !wn;
    tick  = ((m_n % PS) == PS - 1);
    phase = (m_period == 0) ? 1'b1 : (((m_ticks / m_period) % 2) == 0);
    pm    = phase ? 32'hFFFFFFFF : 32'd0;
    for (int i = 0; i < 2; i++) begin
      md = (i == 0) ? 256 : 16;
      on = (m_duty[i] == md - 1) || ((m_n % md) < m_duty[i]);
      m_out[i] = on ? (m_data & (~m_mode | pm) & DMASK) : 32'd0;
    end
    if (wr && addr == 3'd5) m_ticks = 0;
    else if (tick) m_ticks++;
    dm = wd & DMASK;
    if (wr) begin
      case (addr)
        3'd0: m_data = dm;
        3'd1: m_data = m_data | dm;
        3'd2: m_data = m_data & ~dm;
        3'd3: m_data = m_data ^ dm;
        3'd4: m_mode = dm;
        3'd5: m_period = wd & 32'hFFFF;
        3'd6: begin m_duty[0] = wd & 32'hFF; m_duty[1] = wd & 32'hF; end
        default: ;
      endcase
    end
    m_n++;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("out_a", 32'(out_a), m_out[0]);
    chk("out_b", 32'(out_b), m_out[1]);
  endtask

  task automatic drive(input logic [2:0] a, input logic [31:0] d, input logic c, input logic w);
    addr = a; wd = d; cs = c; wn = w;
    cycle();
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    addr = a;
    #1;
    chk($sformatf("rd_a[%0d]", a), rd_a, m_read(a, 0));
    chk($sformatf("rd_b[%0d]", a), rd_b, m_read(a, 1));
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b1, 32'h000F0,    32'h000F0, 32'h000F0};
    vecs[1]  = '{3'd1, 1'b1, 32'h00003,    32'h0,     32'h000F3};
    vecs[2]  = '{3'd2, 1'b1, 32'h00030,    32'h0,     32'h000C3};
    vecs[3]  = '{3'd3, 1'b1, 32'h000FF,    32'h0,     32'h0003C};
    vecs[4]  = '{3'd0, 1'b0, 32'h00001,    32'h0003C, 32'h0003C};
    vecs[5]  = '{3'd7, 1'b1, 32'hFFFFFFFF, 32'h0,     32'h0003C};
    vecs[6]  = '{3'd4, 1'b1, 32'hFFFFFFFF, 32'h3FFFF, 32'h0003C};
    vecs[7]  = '{3'd4, 1'b1, 32'h0,        32'h0,     32'h0003C};
    vecs[8]  = '{3'd6, 1'b1, 32'h1FF,      32'hFF,    32'h0003C};
    vecs[9]  = '{3'd5, 1'b1, 32'h12345,    32'h2345,  32'h0003C};
    vecs[10] = '{3'd5, 1'b1, 32'd500,      32'd500,   32'h0003C};
    vecs[11] = '{3'd0, 1'b1, 32'hFFFFFFFF, 32'h3FFFF, 32'h3FFFF};

    rst = 1'b1; addr = 3'd0; cs = 1'b0; wn = 1'b1; wd = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_a", 32'(out_a), 32'd0);
    chk("reset_out_b", 32'(out_b), 32'd0);
    for (int a = 0; a < 8; a++) rd(3'(a));
    addr = 3'd5; #1; chk("reset_period", rd_a, 32'd500);
    addr = 3'd6; #1; chk("reset_duty", rd_a, 32'hFF);
    rst = 1'b0;
    cycle();

    // DATA write, readback and one-edge output latency
    wr(3'd0, 32'h2A5A5);
    chk("t1_out_latency", 32'(out_a), 32'd0);
    addr = 3'd0; #1; chk("t1_rd_data", rd_a, 32'h0002A5A5);
    cycle();
    chk("t1_out", 32'(out_a), 32'h2A5A5);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].d, vecs[i].c, 1'b0);
      addr = vecs[i].a; #1;
      chk($sformatf("tbl%0d_rd", i), rd_a, vecs[i].exp_rd);
      addr = 3'd0; #1;
      chk($sformatf("tbl%0d_data", i), rd_a, vecs[i].exp_data);
    end

    // PWM on the 4-bit instance
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd1);
    wr(3'd6, 32'd4);
    cycle(); cycle();
    cnt = 0;
    repeat (32) begin cycle(); cnt += int'(out_b[0]); end
    chk("pwm_duty4", 32'(cnt), 32'd8);
    wr(3'd6, 32'd0);
    cycle(); cycle();
    cnt = 0;
    repeat (32) begin cycle(); cnt += int'(out_b[0]); end
    chk("pwm_duty0", 32'(cnt), 32'd0);
    wr(3'd6, 32'd15);
    cycle(); cycle();
    cnt = 0;
    repeat (32) begin cycle(); cnt += int'(out_b[0]); end
    chk("pwm_duty15", 32'(cnt), 32'd32);

    // Blink: PRESCALE=4, PERIOD=3 -> bit0 toggles every 12 clocks
    wr(3'd0, 32'd3);
    wr(3'd6, 32'hFF);
    wr(3'd4, 32'd1);
    wr(3'd5, 32'd3);
    cycle();
    prev = int'(out_a[0]); last = -1; nint = 0; bad = 0;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (out_a[1] !== 1'b1) bad++;
      if (int'(out_a[0]) != prev) begin
        if (last >= 0) begin
          chk("blink_interval", 32'(k - last), 32'd12);
          nint++;
        end
        last = k;
        prev = int'(out_a[0]);
      end
    end
    chk("blink_bit1_static", 32'(bad), 32'd0);
    chk("blink_intervals_seen", 32'(nint >= 3), 32'd1);
    wr(3'd5, 32'd0);
    cycle();
    bad = 0;
    repeat (30) begin cycle(); if (out_a[0] !== 1'b1) bad++; end
    chk("blink_period0_solid", 32'(bad), 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      logic [2:0]  ra;
      logic [31:0] rdv;
      ra  = 3'($urandom_range(0, 7));
      rdv = $urandom;
      if (ra == 3'd5) rdv = $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) cycle();
      else drive(ra, rdv, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0));
      rd(3'($urandom_range(0, 7)));
    end

    // Reset in the middle of blinking
    wr(3'd0, 32'h3FFFF);
    wr(3'd6, 32'hFF);
    wr(3'd4, 32'h3FFFF);
    wr(3'd5, 32'd2);
    repeat (10) cycle();
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_a", 32'(out_a), 32'd0);
    chk("midrst_out_b", 32'(out_b), 32'd0);
    model_reset();
    for (int a = 0; a < 8; a++) rd(3'(a));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    addr = 3'd6; #1; chk("post_rst_duty", rd_a, 32'hFF);
    addr = 3'd5; #1; chk("post_rst_period", rd_a, 32'd500);
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
